sample_read_arbiter: RTL and testbench
======================================

SAMPLE_READ_ARBITER -- requirements
Module: sample_read_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd200: maximum grant length in cycles before forced release; legal range 1..255.
REQ-002 Port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port RST_B  input  1  asynchronous, active-low reset.
REQ-004 Port DAQ_REQ  input  1  level request from the L1A transfer sequencer; held until granted.
REQ-005 Port DAQ_DONE  input  1  one-cycle pulse; DAQ owner releases the sample-buffer read port.
REQ-006 Port JTAG_REQ  input  1  level request from the JTAG readout path; held until granted.
REQ-007 Port JTAG_DONE  input  1  one-cycle pulse; JTAG owner releases the read port.
REQ-008 Port JTAG_MODE  input  1  1 = DAQ requests are ineligible.
REQ-009 Port DAQ_GNT  output  1  DAQ owns the read port.
REQ-010 Port JTAG_GNT  output  1  JTAG owns the read port.
REQ-011 Port RD_SEL  output  1  read-port mux select; 0 = DAQ, 1 = JTAG.
REQ-012 Port BUSY  output  1  1 in any state other than Idle.
REQ-013 Port TIMEOUT_ERR  output  1  one-cycle pulse on a forced release.
REQ-014 Port XSTATE  output  3  voted state encoding, for debug.

Function
REQ-015 States and encodings: Idle=000, Gnt_Daq=001, Gnt_Jtag=010, Release=011; encodings 1xx are illegal and SHALL return to Idle on the next cycle.
REQ-016 DAQ eligible = DAQ_REQ & !JTAG_MODE; JTAG eligible = JTAG_REQ.
REQ-017 From Idle, exactly one eligible requester: go to its Gnt state on the next edge.
REQ-018 From Idle, both eligible: grant the requester not served last (round robin). After reset the last-served flag = JTAG, so DAQ wins the first tie.
REQ-019 From Idle, none eligible: stay in Idle.
REQ-020 DAQ_GNT is registered and equals (state==Gnt_Daq); JTAG_GNT equals (state==Gnt_Jtag). The two grants SHALL never both be 1.
REQ-021 RD_SEL SHALL be 1 in Gnt_Jtag and 0 in Gnt_Daq. In Release and Idle it SHALL hold its last value.
REQ-022 Grant latency: request asserted at edge N gives the grant visible after edge N+1, when in Idle.
REQ-023 Gnt_X with X_DONE=1: go to Release; the grant deasserts on the cycle after DONE. DONE from the non-owner SHALL be ignored.
REQ-024 Release lasts exactly one cycle with no grant (bus turnaround), then the state goes to Idle. Re-arbitration SHALL happen only from Idle.
REQ-025 Timeout counter: 8 bits; cleared on entry to a Gnt state; increments each cycle in a Gnt state; saturates at 255.
REQ-026 Counter == TIMEOUT-1 in a Gnt state with DONE=0: go to Release and pulse TIMEOUT_ERR for one cycle, coincident with Release.
REQ-027 DONE and timeout in the same cycle: normal release; TIMEOUT_ERR stays 0.
REQ-028 JTAG_MODE rising while in Gnt_Daq: the current DAQ grant completes normally and is not pre-empted.
REQ-029 The last-served flag updates on entry to a Gnt state.

Reset
REQ-030 RST_B=0 SHALL asynchronously force:
  - state = Idle
  - DAQ_GNT=0, JTAG_GNT=0, RD_SEL=0, BUSY=0, TIMEOUT_ERR=0
  - counter = 0
  - last-served = JTAG
REQ-031 Reset asserted mid-grant SHALL drop the grant immediately, with no Release cycle. The first arbitration after deassertion SHALL occur on the second rising edge.

Structure
REQ-032 State, counter and last-served flag SHALL be triplicated registers with majority voting. Next-state logic SHALL be computed per copy from voted values.
REQ-033 State encodings and the TIMEOUT default SHALL live in a shared package used by the transfer and JTAG readout blocks.
REQ-034 A sub-module tmr_vote (parameterised-width bitwise 2-of-3 majority) SHALL be used for every voted register.

Verification
REQ-035 DAQ_REQ=1 only -> DAQ_GNT=1 two edges later. DAQ_DONE pulse -> DAQ_GNT=0 next cycle, BUSY=1 for one Release cycle, then Idle.
REQ-036 DAQ_REQ=JTAG_REQ=1 held continuously, DONE after 3 grant cycles each -> grant order DAQ, JTAG, DAQ, JTAG; never both grants high.
REQ-037 JTAG_MODE=1, DAQ_REQ=1 -> no DAQ_GNT. JTAG_REQ=1 -> JTAG_GNT=1 and RD_SEL=1.
REQ-038 TIMEOUT=5, grant DAQ, never DONE -> DAQ_GNT high exactly 5 cycles, TIMEOUT_ERR single pulse in Release.
REQ-039 RST_B=0 asynchronously mid Gnt_Jtag -> JTAG_GNT=0 before the next edge. After release, tie DAQ/JTAG -> DAQ granted.
REQ-040 Force a voted-copy upset: flip one state copy to 111 -> outputs unaffected and the copy resynchronises next cycle.

Source files
------------

// File: rtl/sample_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sample_read_arbiter_pkg
//
// Purpose : Shared definitions for the sample-buffer read-port arbiter and
//           the blocks that talk to it (L1A transfer sequencer, JTAG readout).
//           Holds the state encoding, the default grant timeout, the
//           last-served flag values and the next-state function that each
//           triplicated copy of the arbiter state evaluates.
//
// Contents:
//   arb_state_t      - FSM state encoding (1xx encodings are illegal)
//   TIMEOUT_DEFAULT  - default maximum grant length in cycles
//   LAST_DAQ/JTAG    - values of the round-robin last-served flag
//   TMR_COPIES       - number of redundant register copies
//   arb_next_t       - bundle of next values for one register copy
//   sat_inc()        - 8-bit saturating increment
//   arb_next()       - next-state / next-counter / next-flag computation
// -----------------------------------------------------------------------------
package sample_read_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_GNT_DAQ  = 3'b001,
        ST_GNT_JTAG = 3'b010,
        ST_RELEASE  = 3'b011
    } arb_state_t;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;

    localparam logic LAST_DAQ  = 1'b0;
    localparam logic LAST_JTAG = 1'b1;

    localparam int TMR_COPIES = 3;

    // Next values for one copy of the protected registers.
    typedef struct packed {
        logic [2:0] state;
        logic [7:0] cnt;
        logic       last;
        logic       timeout_err;
    } arb_next_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // All inputs to this function are voted (or primary) values, so every
    // copy that evaluates it computes the same result; a corrupted copy is
    // therefore overwritten with the majority's next value on the next edge.
    //   limit : TIMEOUT-1, the counter value on which a grant is forced off
    //   arb_en: low for the first edge after reset, blocks arbitration
    function automatic arb_next_t arb_next(
        input logic [2:0] st,
        input logic [7:0] cnt,
        input logic       last,
        input logic       daq_elig,
        input logic       jtag_elig,
        input logic       daq_done,
        input logic       jtag_done,
        input logic       arb_en,
        input logic [7:0] limit
    );
        arb_next_t n;
        n.state       = ST_IDLE;
        n.cnt         = 8'd0;
        n.last        = last;
        n.timeout_err = 1'b0;

        case (st)
            ST_IDLE: begin
                if (arb_en) begin
                    // Tie goes to whoever was not served last.
                    if (daq_elig && (!jtag_elig || (last == LAST_JTAG))) begin
                        n.state = ST_GNT_DAQ;
                        n.last  = LAST_DAQ;
                    end else if (jtag_elig) begin
                        n.state = ST_GNT_JTAG;
                        n.last  = LAST_JTAG;
                    end
                end
            end

            ST_GNT_DAQ: begin
                n.cnt = sat_inc(cnt);
                if (daq_done) begin
                    n.state = ST_RELEASE;
                end else if (cnt == limit) begin
                    n.state       = ST_RELEASE;
                    n.timeout_err = 1'b1;
                end else begin
                    n.state = ST_GNT_DAQ;
                end
            end

            ST_GNT_JTAG: begin
                n.cnt = sat_inc(cnt);
                if (jtag_done) begin
                    n.state = ST_RELEASE;
                end else if (cnt == limit) begin
                    n.state       = ST_RELEASE;
                    n.timeout_err = 1'b1;
                end else begin
                    n.state = ST_GNT_JTAG;
                end
            end

            // Release is a single turnaround cycle; illegal codes recover
            // through Idle as well.
            default: begin
                n.state = ST_IDLE;
            end
        endcase

        return n;
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// -----------------------------------------------------------------------------
// tmr_vote
//
// Purpose : Bitwise 2-of-3 majority voter for triplicated registers.
//
// Parameters:
//   WIDTH   - number of bits per copy
// Ports:
//   copy_a  - first register copy
//   copy_b  - second register copy
//   copy_c  - third register copy
//   voted   - per-bit majority of the three copies
// -----------------------------------------------------------------------------
module tmr_vote #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] copy_a,
    input  logic [WIDTH-1:0] copy_b,
    input  logic [WIDTH-1:0] copy_c,
    output logic [WIDTH-1:0] voted
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign voted[gi] = (copy_a[gi] & copy_b[gi])
                         | (copy_a[gi] & copy_c[gi])
                         | (copy_b[gi] & copy_c[gi]);
    end

endmodule

// File: rtl/sample_read_arbiter.sv
// -----------------------------------------------------------------------------
// sample_read_arbiter
//
// Purpose : Arbitrates the sample-buffer read port between the DAQ transfer
//           sequencer and the JTAG readout path. Round-robin on ties, a
//           one-cycle Release turnaround after every grant, and a forced
//           release when a grant exceeds TIMEOUT cycles. State, grant
//           counter and last-served flag are triplicated and voted.
//
// Parameters:
//   TIMEOUT     - maximum grant length in cycles (1..255)
// Ports:
//   CLK         - clock, rising edge active
//   RST_B       - asynchronous active-low reset
//   DAQ_REQ     - DAQ level request, held until granted
//   DAQ_DONE    - one-cycle pulse, DAQ releases the read port
//   JTAG_REQ    - JTAG level request, held until granted
//   JTAG_DONE   - one-cycle pulse, JTAG releases the read port
//   JTAG_MODE   - 1 makes DAQ requests ineligible
//   DAQ_GNT     - DAQ owns the read port
//   JTAG_GNT    - JTAG owns the read port
//   RD_SEL      - read mux select, 0 = DAQ, 1 = JTAG, held outside grants
//   BUSY        - FSM not in Idle
//   TIMEOUT_ERR - one-cycle pulse during a Release caused by timeout
//   XSTATE      - voted state encoding for debug
// -----------------------------------------------------------------------------
module sample_read_arbiter
    import sample_read_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       DAQ_REQ,
    input  logic       DAQ_DONE,
    input  logic       JTAG_REQ,
    input  logic       JTAG_DONE,
    input  logic       JTAG_MODE,
    output logic       DAQ_GNT,
    output logic       JTAG_GNT,
    output logic       RD_SEL,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    output logic [2:0] XSTATE
);

    // Counter value in the last allowed grant cycle.
    localparam logic [7:0] LIMIT = TIMEOUT - 8'd1;

    logic [2:0] state_copy [TMR_COPIES];
    logic [7:0] cnt_copy   [TMR_COPIES];
    logic       last_copy  [TMR_COPIES];
    logic       err_copy   [TMR_COPIES];

    logic [2:0] state_vote;
    logic [7:0] cnt_vote;
    logic       last_vote;
    logic       err_vote;

    logic       daq_elig;
    logic       jtag_elig;
    logic       arb_en_reg;
    logic       rd_sel_reg;

    assign daq_elig  = DAQ_REQ & ~JTAG_MODE;
    assign jtag_elig = JTAG_REQ;

    // Holds arbitration off for the first edge after reset release so that
    // the first grant can only be taken on the second rising edge.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            arb_en_reg <= 1'b0;
        end else begin
            arb_en_reg <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Triplicated state: each copy has its own next-state logic, fed only by
    // voted values, and its own register.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < TMR_COPIES; gi++) begin : g_tmr
        logic [2:0] state_reg;
        logic [7:0] cnt_reg;
        logic       last_reg;
        logic       err_reg;
        arb_next_t  nxt;

        // Next-state logic for this copy.
        always_comb begin
            nxt = arb_next(state_vote, cnt_vote, last_vote,
                           daq_elig, jtag_elig, DAQ_DONE, JTAG_DONE,
                           arb_en_reg, LIMIT);
        end

        // State register for this copy.
        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= 8'd0;
                last_reg  <= LAST_JTAG;
                err_reg   <= 1'b0;
            end else begin
                state_reg <= nxt.state;
                cnt_reg   <= nxt.cnt;
                last_reg  <= nxt.last;
                err_reg   <= nxt.timeout_err;
            end
        end

        assign state_copy[gi] = state_reg;
        assign cnt_copy[gi]   = cnt_reg;
        assign last_copy[gi]  = last_reg;
        assign err_copy[gi]   = err_reg;
    end

    tmr_vote #(.WIDTH(3)) u_vote_state (
        .copy_a (state_copy[0]),
        .copy_b (state_copy[1]),
        .copy_c (state_copy[2]),
        .voted  (state_vote)
    );

    tmr_vote #(.WIDTH(8)) u_vote_cnt (
        .copy_a (cnt_copy[0]),
        .copy_b (cnt_copy[1]),
        .copy_c (cnt_copy[2]),
        .voted  (cnt_vote)
    );

    tmr_vote #(.WIDTH(1)) u_vote_last (
        .copy_a (last_copy[0]),
        .copy_b (last_copy[1]),
        .copy_c (last_copy[2]),
        .voted  (last_vote)
    );

    tmr_vote #(.WIDTH(1)) u_vote_err (
        .copy_a (err_copy[0]),
        .copy_b (err_copy[1]),
        .copy_c (err_copy[2]),
        .voted  (err_vote)
    );

    // -------------------------------------------------------------------------
    // Outputs: decoded from the voted state register, so grants are glitch-
    // free and drop as soon as reset clears the state.
    // -------------------------------------------------------------------------
    always_comb begin
        DAQ_GNT  = 1'b0;
        JTAG_GNT = 1'b0;
        RD_SEL   = rd_sel_reg;
        BUSY     = (state_vote != ST_IDLE);
        case (state_vote)
            ST_GNT_DAQ: begin
                DAQ_GNT = 1'b1;
                RD_SEL  = 1'b0;
            end
            ST_GNT_JTAG: begin
                JTAG_GNT = 1'b1;
                RD_SEL   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Remembers the last mux select so Release/Idle keep the port steered
    // at the most recent owner.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            rd_sel_reg <= 1'b0;
        end else begin
            rd_sel_reg <= RD_SEL;
        end
    end

    assign TIMEOUT_ERR = err_vote;
    assign XSTATE      = state_vote;

endmodule

// File: tb/tb_sample_read_arbiter.sv
module tb_sample_read_arbiter;

    logic       CLK;
    logic       RST_B;
    logic       DAQ_REQ;
    logic       DAQ_DONE;
    logic       JTAG_REQ;
    logic       JTAG_DONE;
    logic       JTAG_MODE;
    logic       DAQ_GNT;
    logic       JTAG_GNT;
    logic       RD_SEL;
    logic       BUSY;
    logic       TIMEOUT_ERR;
    logic [2:0] XSTATE;

    sample_read_arbiter #(.TIMEOUT(8'd5)) dut (
        .CLK         (CLK),
        .RST_B       (RST_B),
        .DAQ_REQ     (DAQ_REQ),
        .DAQ_DONE    (DAQ_DONE),
        .JTAG_REQ    (JTAG_REQ),
        .JTAG_DONE   (JTAG_DONE),
        .JTAG_MODE   (JTAG_MODE),
        .DAQ_GNT     (DAQ_GNT),
        .JTAG_GNT    (JTAG_GNT),
        .RD_SEL      (RD_SEL),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .XSTATE      (XSTATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // stim = {DAQ_REQ, DAQ_DONE, JTAG_REQ, JTAG_DONE, JTAG_MODE}
    // exp  = {DAQ_GNT, JTAG_GNT, RD_SEL, BUSY, TIMEOUT_ERR, XSTATE[2:0]}
    typedef struct {
        string      name;
        logic [4:0] stim;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   both_high = 0;

    localparam logic [7:0] O_IDLE = 8'b0_0_0_0_0_000;
    localparam logic [7:0] O_GD   = 8'b1_0_0_1_0_001;
    localparam logic [7:0] O_GJ   = 8'b0_1_1_1_0_010;
    localparam logic [7:0] O_RD0  = 8'b0_0_0_1_0_011;
    localparam logic [7:0] O_RD1  = 8'b0_0_1_1_0_011;
    localparam logic [7:0] O_ID1  = 8'b0_0_1_0_0_000;
    localparam logic [7:0] O_RTO  = 8'b0_0_0_1_1_011;

    always @(negedge CLK) begin
        if (DAQ_GNT && JTAG_GNT) both_high++;
    end

    function automatic logic [7:0] obs();
        return {DAQ_GNT, JTAG_GNT, RD_SEL, BUSY, TIMEOUT_ERR, XSTATE};
    endfunction

    task automatic add(input string n, input logic [4:0] s, input logic [7:0] e);
        vec_t v;
        v.name = n;
        v.stim = s;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", n, act, exp);
        end else begin
            $display("ok   %s: %b", n, act);
        end
    endtask

    task automatic drive(input logic [4:0] s);
        {DAQ_REQ, DAQ_DONE, JTAG_REQ, JTAG_DONE, JTAG_MODE} = s;
    endtask

    // Apply inputs one cycle, then sample just after the edge.
    task automatic step(input logic [4:0] s);
        drive(s);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_B = 1'b0;
        drive(5'b00000);

        // Single DAQ request, done, release, idle
        add("idle_after_rst",  5'b00000, O_IDLE);
        add("daq_only_gnt",    5'b10000, O_GD);
        add("daq_hold",        5'b00000, O_GD);
        add("daq_done_rel",    5'b01000, O_RD0);
        add("daq_to_idle",     5'b00000, O_IDLE);
        // JTAG_MODE blocks DAQ; JTAG grant; non-owner DONE ignored
        add("jm_daq_blocked",  5'b10001, O_IDLE);
        add("jm_jtag_gnt",     5'b10101, O_GJ);
        add("nonowner_done",   5'b11001, O_GJ);
        add("jtag_done_rel",   5'b10011, O_RD1);
        add("idle_sel_held",   5'b00000, O_ID1);
        // Both held: DAQ, JTAG, DAQ, JTAG
        add("rr1_daq",         5'b10100, O_GD);
        add("rr1_hold_a",      5'b10100, O_GD);
        add("rr1_hold_b",      5'b10100, O_GD);
        add("rr1_done",        5'b11100, O_RD0);
        add("rr1_idle",        5'b10100, O_IDLE);
        add("rr2_jtag",        5'b10100, O_GJ);
        add("rr2_hold_a",      5'b10100, O_GJ);
        add("rr2_hold_b",      5'b10100, O_GJ);
        add("rr2_done",        5'b10110, O_RD1);
        add("rr2_idle",        5'b10100, O_ID1);
        add("rr3_daq",         5'b10100, O_GD);
        add("rr3_done",        5'b11100, O_RD0);
        add("rr3_idle",        5'b10100, O_IDLE);
        add("rr4_jtag",        5'b10100, O_GJ);
        add("rr4_done",        5'b00010, O_RD1);
        add("rr4_idle",        5'b00000, O_ID1);
        // Timeout (TIMEOUT=5): grant for exactly 5 cycles then forced release
        add("to_gnt",          5'b10000, O_GD);
        for (int i = 0; i < 4; i++) add("to_hold", 5'b00000, O_GD);
        add("to_fire",         5'b00000, O_RTO);
        add("to_idle",         5'b00000, O_IDLE);
        // DONE coincident with timeout: normal release
        add("lim_gnt",         5'b10000, O_GD);
        for (int i = 0; i < 4; i++) add("lim_hold", 5'b00000, O_GD);
        add("done_at_limit",   5'b01000, O_RD0);
        add("lim_idle",        5'b00000, O_IDLE);
        // JTAG_MODE rising during a DAQ grant does not pre-empt it
        add("jmr_gnt",         5'b10000, O_GD);
        add("jmr_no_preempt",  5'b00001, O_GD);
        add("jmr_done",        5'b01001, O_RD0);
        add("jmr_idle",        5'b00000, O_IDLE);

        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", obs(), O_IDLE);
        RST_B = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].stim);
            check(vecs[i].name, obs(), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a JTAG grant
        step(5'b00100);
        check("rst_pre_gj", obs(), O_GJ);
        #2;
        RST_B = 1'b0;
        #1;
        check("rst_async_drop_j", obs(), O_IDLE);
        drive(5'b00000);
        @(negedge CLK);
        RST_B = 1'b1;
        step(5'b10100);
        check("rst_first_edge_idle", obs(), O_IDLE);
        step(5'b10100);
        check("rst_tie_daq", obs(), O_GD);
        step(5'b01000);
        check("rst_seq_rel", obs(), O_RD0);
        step(5'b00000);
        check("rst_seq_idle", obs(), O_IDLE);

        // Upset one state copy to an illegal code during a DAQ grant
        step(5'b10000);
        check("upset_pre_gd", obs(), O_GD);
        drive(5'b00000);
        @(negedge CLK);
        force dut.g_tmr[1].state_reg = 3'b111;
        #1;
        check("upset_outputs", obs(), O_GD);
        release dut.g_tmr[1].state_reg;
        @(posedge CLK);
        #1;
        check("upset_copy_resync", {5'b0, dut.g_tmr[1].state_reg}, 8'b0000_0001);
        check("upset_after", obs(), O_GD);

        // Reset during a DAQ grant: last-served returns to JTAG, DAQ wins tie
        #2;
        RST_B = 1'b0;
        #1;
        check("rst_async_drop_d", obs(), O_IDLE);
        @(negedge CLK);
        RST_B = 1'b1;
        step(5'b10100);
        check("rst2_first_edge_idle", obs(), O_IDLE);
        step(5'b10100);
        check("rst2_tie_daq", obs(), O_GD);
        step(5'b01000);
        check("rst2_rel", obs(), O_RD0);
        step(5'b00000);
        check("rst2_idle", obs(), O_IDLE);

        check("grant_exclusive", 8'(both_high), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
